branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter: ENTRIES, 64, number of BTB entries, power of two, 4..1024.
REQ-002 Parameter: TAG_BITS, 12, stored tag width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 lookup_valid_i  input  1  fetch-stage prediction request.
REQ-006 lookup_pc_i  input  64  PC to predict.
REQ-007 flush_i  input  1  invalidate all BTB entries.
REQ-008 update_valid_i  input  1  resolved-branch update from the branch execution unit.
REQ-009 update_pc_i  input  64  PC of the resolved branch.
REQ-010 update_ctrl_i  input  3  branch type: BEQ=0, BNE=1, BLT=2, BGE=3, BLTU=4, BGEU=5, JAL=6, JALR=7.
REQ-011 update_taken_i  input  1  actual taken outcome.
REQ-012 update_target_i  input  64  actual target.
REQ-013 update_mispredict_i  input  1  resolution flagged a misprediction.
REQ-014 pred_valid_o  output  1  prediction valid, one cycle after the request.
REQ-015 pred_taken_o  output  1  predicted taken.
REQ-016 pred_target_o  output  64  predicted next PC.
REQ-017 update_cnt_o  output  32  count of accepted updates, saturating.
REQ-018 mispredict_cnt_o  output  32  count of updates with mispredict set, saturating.

Function
REQ-019 Index SHALL be pc[log2(ENTRIES)+1:2]; tag SHALL be the next TAG_BITS bits above the index.
REQ-020 Each entry SHALL hold: valid, tag, 64-bit target, 2-bit saturating counter, uncond bit.
REQ-021 A hit SHALL mean entry valid and stored tag equal to the lookup tag.
REQ-022 Lookup latency SHALL be exactly 1 cycle: pred_valid_o = registered lookup_valid_i; the other pred outputs are registered alongside it.
REQ-023 pred_taken_o SHALL be hit && (uncond || ctr[1]).
REQ-024 pred_target_o SHALL be the entry target when pred_taken_o=1, otherwise lookup_pc_i+4 (64-bit wrap, no carry out).
REQ-025 When lookup_valid_i=0, pred_valid_o SHALL be 0 next cycle, and pred_taken_o/pred_target_o SHALL hold their previous values.
REQ-026 Update hit: the counter SHALL increment on taken and decrement on not-taken, saturating at 3 and 0; if taken, target SHALL be overwritten with update_target_i; uncond SHALL be set to (ctrl==6||ctrl==7).
REQ-027 Update miss with update_taken_i=1: the entry SHALL be allocated (overwriting any victim) with valid=1, new tag, target, ctr=2'b10, and uncond per REQ-026.
REQ-028 Update miss with update_taken_i=0: the BTB SHALL be unchanged.
REQ-029 Lookup and update to the same index in the same cycle: the lookup SHALL observe the pre-update entry (no bypass).
REQ-030 flush_i SHALL clear every valid bit in one cycle; counters and targets are not required to clear.
REQ-031 flush_i and update_valid_i in the same cycle: flush SHALL win, and the update SHALL be dropped from the BTB but still counted.
REQ-032 A lookup in a flush cycle SHALL yield pred_valid_o=1 and pred_taken_o=0 next cycle.
REQ-033 update_cnt_o SHALL increment per update_valid_i cycle; mispredict_cnt_o SHALL increment when update_valid_i && update_mispredict_i; both SHALL stop at 32'hFFFF_FFFF.

Reset
REQ-034 While rst=1, regardless of clk: all valid bits = 0; all counters = 2'b01; pred_valid_o = 0; pred_taken_o = 0; pred_target_o = 0; both count outputs = 0.
REQ-035 Reset asserted mid-operation SHALL discard any in-flight lookup; pred_valid_o SHALL be 0 in the first cycle after deassertion.

Verification
REQ-036 After reset: lookup pc=0x1000 -> next cycle pred_valid=1, taken=0, target=0x1004.
REQ-037 Update pc=0x1000, ctrl=0 (BEQ), taken=1, target=0x2000, then lookup 0x1000 -> taken=1, target=0x2000; two not-taken updates -> lookup taken=0, target=0x1004.
REQ-038 JAL update pc=0x3000 with target 0x3800, then four not-taken updates -> lookup still taken=1, target=0x3800 (uncond).
REQ-039 Aliasing: allocate pc=0x1000, then look up pc=0x1000+(ENTRIES*4) -> miss, taken=0; a taken update at the alias replaces the entry, and lookup 0x1000 -> miss.
REQ-040 Same cycle: flush, update pc=0x1000 taken, and lookup pc=0x1000 -> next cycle taken=0, update_cnt_o=1, no allocation on later lookup.
REQ-041 Force mispredict_cnt_o to 32'hFFFF_FFFE, apply 3 mispredict updates -> value 32'hFFFF_FFFF; assert rst mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch/resolve bus of the branch target buffer: lookup request and registered
// prediction, resolved-branch update, flush and the two event counters.
interface branch_predictor_if;
    logic        lookup_valid_i;
    logic [63:0] lookup_pc_i;
    logic        flush_i;
    logic        update_valid_i;
    logic [63:0] update_pc_i;
    logic [2:0]  update_ctrl_i;
    logic        update_taken_i;
    logic [63:0] update_target_i;
    logic        update_mispredict_i;
    logic        pred_valid_o;
    logic        pred_taken_o;
    logic [63:0] pred_target_o;
    logic [31:0] update_cnt_o;
    logic [31:0] mispredict_cnt_o;

    modport master (
        output lookup_valid_i, lookup_pc_i, flush_i,
        output update_valid_i, update_pc_i, update_ctrl_i, update_taken_i,
        output update_target_i, update_mispredict_i,
        input  pred_valid_o, pred_taken_o, pred_target_o,
        input  update_cnt_o, mispredict_cnt_o
    );

    modport slave (
        input  lookup_valid_i, lookup_pc_i, flush_i,
        input  update_valid_i, update_pc_i, update_ctrl_i, update_taken_i,
        input  update_target_i, update_mispredict_i,
        output pred_valid_o, pred_taken_o, pred_target_o,
        output update_cnt_o, mispredict_cnt_o
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters and an
// unconditional-jump bit; one-cycle registered prediction, no update bypass.
module branch_predictor #(
    parameter int ENTRIES  = 64,
    parameter int TAG_BITS = 12
) (
    input logic              clk,
    input logic              rst,
    branch_predictor_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    typedef logic [IDX_W-1:0]    idx_t;
    typedef logic [TAG_BITS-1:0] tag_t;

    typedef enum logic [2:0] {
        CTRL_BEQ  = 3'd0, CTRL_BNE  = 3'd1, CTRL_BLT = 3'd2, CTRL_BGE  = 3'd3,
        CTRL_BLTU = 3'd4, CTRL_BGEU = 3'd5, CTRL_JAL = 3'd6, CTRL_JALR = 3'd7
    } br_ctrl_e;

    logic        valid_q  [ENTRIES];
    logic [1:0]  ctr_q    [ENTRIES];
    tag_t        tag_q    [ENTRIES];
    logic [63:0] target_q [ENTRIES];
    logic        uncond_q [ENTRIES];

    logic        pred_valid_q;
    logic        pred_taken_q;
    logic [63:0] pred_target_q;
    logic [31:0] update_cnt;
    logic [31:0] mispredict_cnt;

    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
        if (taken)
            return (c == 2'b11) ? c : c + 2'b01;
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    idx_t        l_idx;
    tag_t        l_tag;
    logic        l_hit;
    logic        l_taken;
    logic [63:0] l_target;
    idx_t        u_idx;
    tag_t        u_tag;
    logic        u_hit;
    logic        u_uncond;
    logic        u_train;
    logic        u_alloc;

    always_comb begin
        l_idx    = bus.lookup_pc_i[IDX_W+1:2];
        l_tag    = bus.lookup_pc_i[IDX_W+2 +: TAG_BITS];
        l_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
        // A flush in the lookup cycle kills the prediction even though the array still holds old state.
        l_taken  = l_hit && (uncond_q[l_idx] || ctr_q[l_idx][1]) && !bus.flush_i;
        l_target = l_taken ? target_q[l_idx] : bus.lookup_pc_i + 64'd4;

        u_idx    = bus.update_pc_i[IDX_W+1:2];
        u_tag    = bus.update_pc_i[IDX_W+2 +: TAG_BITS];
        u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        u_uncond = (bus.update_ctrl_i == CTRL_JAL) || (bus.update_ctrl_i == CTRL_JALR);
        u_train  = bus.update_valid_i && !bus.flush_i && u_hit;
        u_alloc  = bus.update_valid_i && !bus.flush_i && !u_hit && bus.update_taken_i;
    end

    // NOTE: only valid and counter bits carry a reset; tag/target/uncond are
    // don't-care while invalid, so they live in a reset-free block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (bus.flush_i) begin
            for (int i = 0; i < ENTRIES; i++)
                valid_q[i] <= 1'b0;
        end else if (u_alloc) begin
            valid_q[u_idx] <= 1'b1;
            ctr_q[u_idx]   <= 2'b10;
        end else if (u_train) begin
            ctr_q[u_idx] <= ctr_step(ctr_q[u_idx], bus.update_taken_i);
        end
    end

    always_ff @(posedge clk) begin
        if (u_alloc) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= bus.update_target_i;
            uncond_q[u_idx] <= u_uncond;
        end else if (u_train) begin
            uncond_q[u_idx] <= u_uncond;
            if (bus.update_taken_i)
                target_q[u_idx] <= bus.update_target_i;
        end
    end

    // Taken/target hold their last value on idle cycles; only the valid flag drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            pred_valid_q <= bus.lookup_valid_i;
            if (bus.lookup_valid_i) begin
                pred_taken_q  <= l_taken;
                pred_target_q <= l_target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            update_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (bus.update_valid_i) begin
            if (update_cnt != 32'hFFFF_FFFF)
                update_cnt <= update_cnt + 32'd1;
            if (bus.update_mispredict_i && (mispredict_cnt != 32'hFFFF_FFFF))
                mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end

    assign bus.pred_valid_o     = pred_valid_q;
    assign bus.pred_taken_o     = pred_taken_q;
    assign bus.pred_target_o    = pred_target_q;
    assign bus.update_cnt_o     = update_cnt;
    assign bus.mispredict_cnt_o = mispredict_cnt;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: lookups push expected predictions,
// a monitor pops and compares them one cycle later.
module tb_branch_predictor;
    localparam int ENTRIES = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_if bus ();

    branch_predictor #(.ENTRIES(ENTRIES), .TAG_BITS(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        taken;
        logic [63:0] target;
    } pred_t;

    pred_t       sb_q[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] exp_upd;
    logic [31:0] exp_mis;
    logic        mon_en = 1'b0;
    logic        mon_lv;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.lookup_valid_i      = 1'b0;
        bus.lookup_pc_i         = '0;
        bus.flush_i             = 1'b0;
        bus.update_valid_i      = 1'b0;
        bus.update_pc_i         = '0;
        bus.update_ctrl_i       = '0;
        bus.update_taken_i      = 1'b0;
        bus.update_target_i     = '0;
        bus.update_mispredict_i = 1'b0;
    endtask

    task automatic lookup(input logic [63:0] pc, input logic et, input logic [63:0] etgt);
        bus.lookup_valid_i = 1'b1;
        bus.lookup_pc_i    = pc;
        sb_q.push_back(pred_t'{taken: et, target: etgt});
        @(negedge clk);
        bus.lookup_valid_i = 1'b0;
    endtask

    task automatic upd_set(input logic [63:0] pc, input logic [2:0] ctrl, input logic taken,
                           input logic [63:0] tgt, input logic mis);
        bus.update_valid_i      = 1'b1;
        bus.update_pc_i         = pc;
        bus.update_ctrl_i       = ctrl;
        bus.update_taken_i      = taken;
        bus.update_target_i     = tgt;
        bus.update_mispredict_i = mis;
        if (exp_upd != 32'hFFFF_FFFF) exp_upd++;
        if (mis && exp_mis != 32'hFFFF_FFFF) exp_mis++;
    endtask

    task automatic update(input logic [63:0] pc, input logic [2:0] ctrl, input logic taken,
                          input logic [63:0] tgt, input logic mis);
        upd_set(pc, ctrl, taken, tgt, mis);
        @(negedge clk);
        bus.update_valid_i = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_update_cnt"}, 64'(bus.update_cnt_o), 64'(exp_upd));
        check({tag, "_mispredict_cnt"}, 64'(bus.mispredict_cnt_o), 64'(exp_mis));
    endtask

    always @(posedge clk) begin
        if (mon_en && !rst) begin
            mon_lv = bus.lookup_valid_i;
            #1;
            check("pred_valid", 64'(bus.pred_valid_o), 64'(mon_lv));
            if (mon_lv) begin
                check("sb_depth", 64'(sb_q.size()), 64'd1);
                if (sb_q.size() != 0) begin
                    pred_t e;
                    e = sb_q.pop_front();
                    check("pred_taken", 64'(bus.pred_taken_o), 64'(e.taken));
                    check("pred_target", bus.pred_target_o, e.target);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        exp_upd = '0;
        exp_mis = '0;
        rst     = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_pred_valid", 64'(bus.pred_valid_o), 64'd0);
        check("rst_pred_taken", 64'(bus.pred_taken_o), 64'd0);
        check("rst_pred_target", bus.pred_target_o, 64'd0);
        check_counts("rst");
        rst    = 1'b0;
        mon_en = 1'b1;

        // Cold lookup falls through to pc+4.
        lookup(64'h1000, 1'b0, 64'h1004);
        @(negedge clk);

        // Conditional branch: allocate weakly taken, then train down and back up.
        update(64'h1000, 3'd0, 1'b1, 64'h2000, 1'b1);
        lookup(64'h1000, 1'b1, 64'h2000);
        update(64'h1000, 3'd0, 1'b0, 64'h0, 1'b1);
        update(64'h1000, 3'd0, 1'b0, 64'h0, 1'b0);
        lookup(64'h1000, 1'b0, 64'h1004);
        update(64'h1000, 3'd1, 1'b1, 64'h2400, 1'b0);
        lookup(64'h1000, 1'b0, 64'h1004);
        update(64'h1000, 3'd1, 1'b1, 64'h2400, 1'b1);
        lookup(64'h1000, 1'b1, 64'h2400);

        // Unconditional jump stays taken however far its counter drops.
        update(64'h3000, 3'd6, 1'b1, 64'h3800, 1'b1);
        for (int i = 0; i < 4; i++)
            update(64'h3000, 3'd6, 1'b0, 64'h0, 1'b0);
        lookup(64'h3000, 1'b1, 64'h3800);

        // Aliasing at the same index with a different tag.
        update(64'h1000, 3'd2, 1'b1, 64'h1800, 1'b0);
        lookup(64'h1000, 1'b1, 64'h1800);
        lookup(64'h1000 + ENTRIES * 4, 1'b0, 64'h1104);
        update(64'h1000 + ENTRIES * 4, 3'd3, 1'b1, 64'h5000, 1'b1);
        lookup(64'h1000 + ENTRIES * 4, 1'b1, 64'h5000);
        lookup(64'h1000, 1'b0, 64'h1004);

        // Not-taken miss must not allocate.
        update(64'h7010, 3'd4, 1'b0, 64'h7777, 1'b0);
        lookup(64'h7010, 1'b0, 64'h7014);

        // Same-cycle update and lookup: lookup sees the pre-update entry.
        upd_set(64'h1000, 3'd5, 1'b1, 64'h6000, 1'b0);
        lookup(64'h1000, 1'b0, 64'h1004);
        bus.update_valid_i = 1'b0;
        lookup(64'h1000, 1'b1, 64'h6000);

        // Counter saturates at 3: one not-taken keeps it taken, the second does not.
        update(64'h2010, 3'd0, 1'b1, 64'h2100, 1'b0);
        update(64'h2010, 3'd0, 1'b1, 64'h2200, 1'b0);
        update(64'h2010, 3'd0, 1'b1, 64'h2300, 1'b0);
        update(64'h2010, 3'd0, 1'b0, 64'h0, 1'b1);
        lookup(64'h2010, 1'b1, 64'h2300);
        update(64'h2010, 3'd0, 1'b0, 64'h0, 1'b1);
        lookup(64'h2010, 1'b0, 64'h2014);
        check_counts("mid");

        // Flush, taken update and lookup in one cycle.
        lookup(64'h1000, 1'b1, 64'h6000);
        upd_set(64'h1000, 3'd0, 1'b1, 64'h2000, 1'b0);
        bus.flush_i = 1'b1;
        lookup(64'h1000, 1'b0, 64'h1004);
        bus.flush_i        = 1'b0;
        bus.update_valid_i = 1'b0;
        check_counts("flush");
        lookup(64'h1000, 1'b0, 64'h1004);
        lookup(64'h3000, 1'b0, 64'h3004);
        lookup(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0);

        // Mispredict counter saturation.
        force dut.mispredict_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.mispredict_cnt;
        exp_mis = 32'hFFFF_FFFE;
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            update(64'h4000, 3'd0, 1'b0, 64'h0, 1'b1);
        check("mispredict_sat", 64'(bus.mispredict_cnt_o), 64'hFFFF_FFFF);
        check_counts("sat");

        // Asynchronous reset with a lookup in flight.
        update(64'h2010, 3'd0, 1'b1, 64'h2A00, 1'b0);
        lookup(64'h2010, 1'b1, 64'h2A00);
        mon_en             = 1'b0;
        bus.lookup_valid_i = 1'b1;
        bus.lookup_pc_i    = 64'h2010;
        #2 rst = 1'b1;
        #1;
        check("arst_pred_valid", 64'(bus.pred_valid_o), 64'd0);
        check("arst_pred_taken", 64'(bus.pred_taken_o), 64'd0);
        check("arst_pred_target", bus.pred_target_o, 64'd0);
        exp_upd = '0;
        exp_mis = '0;
        check_counts("arst");
        @(negedge clk);
        rst                = 1'b0;
        bus.lookup_valid_i = 1'b0;
        #1;
        check("post_rst_valid0", 64'(bus.pred_valid_o), 64'd0);
        @(posedge clk);
        #1;
        check("post_rst_valid1", 64'(bus.pred_valid_o), 64'd0);
        @(negedge clk);
        mon_en = 1'b1;
        lookup(64'h2010, 1'b0, 64'h2014);
        @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
